// File: rtl/hdmi_info_frame_pkg.sv
// Shared constants and types for the HDMI InfoFrame receivers.
// SPD_TYPE/SPD_VERSION/SPD_LENGTH describe the Source Product Description
// InfoFrame; index constants are byte positions within HB0..HB2, PB0..PB27.
package hdmi_info_frame_pkg;

  localparam logic [7:0]  SPD_TYPE            = 8'h83;
  localparam logic [7:0]  SPD_VERSION         = 8'h01;
  localparam logic [4:0]  SPD_LENGTH          = 5'd25;

  localparam int unsigned INFO_FRAME_HB_BYTES = 3;
  localparam int unsigned INFO_FRAME_PB_BYTES = 28;

  // Byte index of PB27, the final byte of every InfoFrame packet.
  localparam logic [4:0]  INFO_FRAME_LAST_IDX =
    5'(INFO_FRAME_HB_BYTES + INFO_FRAME_PB_BYTES - 1);
  // Byte index of PB[SPD_LENGTH], the last byte covered by the checksum.
  localparam logic [4:0]  SPD_CSUM_LAST_IDX   = 5'(INFO_FRAME_HB_BYTES) + SPD_LENGTH;
  // Payload bytes committed to outputs: PB1..PB25.
  localparam int unsigned SPD_STAGE_BYTES     = 25;

  typedef enum logic [1:0] {IDLE, HDR, BODY, SKIP} info_frame_rx_state_t;

endpackage

// File: rtl/source_product_description_info_frame_receiver_if.sv
// Byte-serial InfoFrame packet stream (from the data-island packet decoder).
//  in_valid : in_byte is valid this cycle
//  in_sop   : in_byte is HB0 (start of packet); only meaningful with in_valid
//  in_byte  : packet byte, HB0..HB2 then PB0..PB27
interface source_product_description_info_frame_receiver_if;
  logic       in_valid;
  logic       in_sop;
  logic [7:0] in_byte;

  modport master (output in_valid, output in_sop, output in_byte);
  modport slave  (input  in_valid, input  in_sop, input  in_byte);
endinterface

// File: rtl/info_frame_checksum_accumulator.sv
// 8-bit wrap-around running sum for InfoFrame checksums.
//  clk_i, rst_ni : clock, asynchronous active-low reset
//  clear_i       : restart the sum (a simultaneous add_en_i loads byte_i)
//  add_en_i      : add byte_i to the sum
//  byte_i        : byte to accumulate
//  is_zero_o     : registered sum equals 0 (combinational compare)
module info_frame_checksum_accumulator (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clear_i,
  input  logic       add_en_i,
  input  logic [7:0] byte_i,
  output logic       is_zero_o
);

  logic [7:0] sum_q, sum_d;

  always_comb begin
    sum_d = clear_i ? '0 : sum_q;
    if (add_en_i) sum_d = sum_d + byte_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sum_q <= '0;
    else         sum_q <= sum_d;
  end

  assign is_zero_o = (sum_q == '0);

endmodule

// File: rtl/source_product_description_info_frame_receiver.sv
// Sink-side parser for the HDMI SPD InfoFrame. Stages PB1..PB25 while a
// frame arrives and commits them to the outputs only when the frame passes.
// Optional build macro: SPD_RX_STRICT_HEADER_EN (also checks HB1 and HB2).
//  clk_pixel                 : pixel clock
//  reset_n                   : asynchronous active-low reset
//  rx                        : packet byte stream (slave modport)
//  frame_valid               : a good frame has been committed since reset
//  frame_update              : 1-cycle pulse per commit
//  checksum_error            : 1-cycle pulse per failed SPD frame
//  vendor_name               : PB1..PB8, PB1 in the low byte
//  product_description       : PB9..PB24, PB9 in the low byte
//  source_device_information : PB25
module source_product_description_info_frame_receiver
  import hdmi_info_frame_pkg::*;
(
  input  logic                                          clk_pixel,
  input  logic                                          reset_n,
  source_product_description_info_frame_receiver_if.slave rx,
  output logic                                          frame_valid,
  output logic                                          frame_update,
  output logic                                          checksum_error,
  output logic [63:0]                                   vendor_name,
  output logic [127:0]                                  product_description,
  output logic [7:0]                                    source_device_information
);

  info_frame_rx_state_t             state_q, state_d;
  logic [4:0]                       idx_q, idx_d;
  logic [8*SPD_STAGE_BYTES-1:0]     stage_q, stage_d;
  logic                             valid_q, valid_d;
  logic                             update_q, update_d;
  logic                             error_q, error_d;
  logic [63:0]                      vendor_q, vendor_d;
  logic [127:0]                     product_q, product_d;
  logic [7:0]                       sdi_q, sdi_d;
  logic                             sop, acc_clear, acc_add, csum_ok, frame_pass;
`ifdef SPD_RX_STRICT_HEADER_EN
  logic                             hdr_ok_q, hdr_ok_d;
`endif

  assign sop = rx.in_valid & rx.in_sop;

  info_frame_checksum_accumulator u_csum (
    .clk_i     (clk_pixel),
    .rst_ni    (reset_n),
    .clear_i   (acc_clear),
    .add_en_i  (acc_add),
    .byte_i    (rx.in_byte),
    .is_zero_o (csum_ok)
  );

  // The sum through PB[SPD_LENGTH] is already registered by the PB27 cycle.
`ifdef SPD_RX_STRICT_HEADER_EN
  assign frame_pass = csum_ok & hdr_ok_q;
`else
  assign frame_pass = csum_ok;
`endif

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    stage_d   = stage_q;
    valid_d   = valid_q;
    update_d  = 1'b0;
    error_d   = 1'b0;
    vendor_d  = vendor_q;
    product_d = product_q;
    sdi_d     = sdi_q;
    acc_clear = 1'b0;
    acc_add   = 1'b0;
`ifdef SPD_RX_STRICT_HEADER_EN
    hdr_ok_d  = hdr_ok_q;
`endif
    if (sop) begin
      // A sop in any state restarts parsing with this byte as HB0.
      acc_clear = 1'b1;
      acc_add   = 1'b1;
      idx_d     = 5'd1;
      state_d   = (rx.in_byte == SPD_TYPE) ? HDR : SKIP;
    end else if (rx.in_valid) begin
      case (state_q)
        HDR: begin
          acc_add = 1'b1;
          idx_d   = idx_q + 5'd1;
`ifdef SPD_RX_STRICT_HEADER_EN
          if (idx_q == 5'd1) hdr_ok_d = (rx.in_byte == SPD_VERSION);
          else               hdr_ok_d = hdr_ok_q && (rx.in_byte[4:0] == SPD_LENGTH)
                                                 && (rx.in_byte[7:5] == 3'b000);
`endif
          if (idx_q == 5'd2) state_d = BODY;
        end
        BODY: begin
          acc_add = (idx_q <= SPD_CSUM_LAST_IDX);
          for (int unsigned n = 1; n <= SPD_STAGE_BYTES; n++) begin
            if (idx_q == 5'(n + INFO_FRAME_HB_BYTES)) stage_d[8*(n-1) +: 8] = rx.in_byte;
          end
          if (idx_q == INFO_FRAME_LAST_IDX) begin
            state_d = IDLE;
            idx_d   = '0;
            if (frame_pass) begin
              update_d  = 1'b1;
              valid_d   = 1'b1;
              vendor_d  = stage_q[63:0];
              product_d = stage_q[191:64];
              sdi_d     = stage_q[199:192];
            end else begin
              error_d   = 1'b1;
            end
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      stage_q   <= '0;
      valid_q   <= 1'b0;
      update_q  <= 1'b0;
      error_q   <= 1'b0;
      vendor_q  <= '0;
      product_q <= '0;
      sdi_q     <= '0;
`ifdef SPD_RX_STRICT_HEADER_EN
      hdr_ok_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      stage_q   <= stage_d;
      valid_q   <= valid_d;
      update_q  <= update_d;
      error_q   <= error_d;
      vendor_q  <= vendor_d;
      product_q <= product_d;
      sdi_q     <= sdi_d;
`ifdef SPD_RX_STRICT_HEADER_EN
      hdr_ok_q  <= hdr_ok_d;
`endif
    end
  end

  assign frame_valid               = valid_q;
  assign frame_update              = update_q;
  assign checksum_error            = error_q;
  assign vendor_name               = vendor_q;
  assign product_description       = product_q;
  assign source_device_information = sdi_q;

endmodule
